// File: rtl/mem_arbiter.sv
// Dual-core arbiter between the L1 caches and the single RAM port; data beats instruction fetch.
// Optional performance counters are enabled with `define ARB_PERF_EN.
module mem_arbiter #(
  parameter int CPUS      = 2,
  parameter int BLK_WORDS = 2
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [CPUS-1:0]      iREN,
  input  logic [CPUS*32-1:0]   iaddr,
  output logic [CPUS*32-1:0]   iload,
  output logic [CPUS-1:0]      iwait,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  logic [CPUS*32-1:0]   daddr,
  input  logic [CPUS*32-1:0]   dstore,
  output logic [CPUS*32-1:0]   dload,
  output logic [CPUS-1:0]      dwait,
  input  logic                 c2c,
  output logic                 dgrant,
  output logic                 dbusy,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [31:0]          ramaddr,
  output logic [31:0]          ramstore,
  input  logic [31:0]          ramload,
  input  logic [1:0]           ramstate
`ifdef ARB_PERF_EN
  ,
  output logic [CPUS*32-1:0]   perf_dgrants,
  output logic [CPUS*32-1:0]   perf_igrants,
  output logic [31:0]          perf_c2c,
  output logic [CPUS*32-1:0]   perf_stall
`endif
);

  localparam int CW = $clog2(BLK_WORDS) + 1;
  localparam logic [CW-1:0] LAST = CW'(BLK_WORDS - 1);

  typedef enum logic [1:0] {IDLE, DATA, INST} state_t;

  state_t          state, state_n;
  logic            owner, owner_n;
  logic            rr, rr_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [CPUS-1:0] dreq;
  logic            access;

  function automatic logic [31:0] pick(input logic [CPUS*32-1:0] v, input logic s);
    return s ? v[32 +: 32] : v[0 +: 32];
  endfunction

  function automatic logic [CPUS*32-1:0] place(input logic [31:0] d, input logic s);
    return s ? {d, 32'h0} : {32'h0, d};
  endfunction

  function automatic logic [CPUS-1:0] sel_bit(input logic s);
    return s ? 2'b10 : 2'b01;
  endfunction

  assign dreq   = dREN | dWEN;
  assign access = (ramstate == 2'd2);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      owner <= 1'b0;
      rr    <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      rr    <= rr_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    owner_n  = owner;
    rr_n     = rr;
    cnt_n    = cnt;
    iload    = '0;
    iwait    = '1;
    dload    = '0;
    dwait    = '1;
    dgrant   = 1'b0;
    dbusy    = 1'b0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (|dreq) begin
          state_n = DATA;
          owner_n = dreq[rr] ? rr : ~rr;
        end else if (|iREN) begin
          state_n = INST;
          owner_n = iREN[rr] ? rr : ~rr;
        end
      end
      DATA: begin
        dgrant = owner;
        dbusy  = 1'b1;
        if (!dreq[owner]) begin
          state_n = IDLE;
          rr_n    = ~owner;
        end else begin
          ramaddr = pick(daddr, owner);
          // A snoop-hit read becomes a write-back of the other core's modified line.
          if (dWEN[owner]) begin
            ramWEN   = 1'b1;
            ramstore = pick(dstore, owner);
          end else if (c2c) begin
            ramWEN   = 1'b1;
            ramstore = pick(dstore, ~owner);
          end else begin
            ramREN = 1'b1;
          end
          if (access) begin
            dwait = ~sel_bit(owner);
            if (!dWEN[owner] && !c2c)
              dload = place(ramload, owner);
            if (cnt == LAST) begin
              state_n = IDLE;
              rr_n    = ~owner;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt + 1'b1;
            end
          end
        end
      end
      INST: begin
        if (!iREN[owner]) begin
          state_n = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = pick(iaddr, owner);
          if (access) begin
            iwait   = ~sel_bit(owner);
            iload   = place(ramload, owner);
            state_n = IDLE;
            rr_n    = ~rr;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef ARB_PERF_EN
  logic c2c_seen;

  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    return (x == '1) ? x : x + 32'd1;
  endfunction

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_dgrants <= '0;
      perf_igrants <= '0;
      perf_c2c     <= '0;
      perf_stall   <= '0;
      c2c_seen     <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < CPUS; i++) begin
        if (state == IDLE && state_n == DATA && owner_n == i[0])
          perf_dgrants[i*32 +: 32] <= sat_inc(perf_dgrants[i*32 +: 32]);
        if (state == IDLE && state_n == INST && owner_n == i[0])
          perf_igrants[i*32 +: 32] <= sat_inc(perf_igrants[i*32 +: 32]);
        if (dwait[i] && dreq[i])
          perf_stall[i*32 +: 32] <= sat_inc(perf_stall[i*32 +: 32]);
      end
      if (state != DATA) begin
        c2c_seen <= 1'b0;
      end else if (c2c && !c2c_seen) begin
        c2c_seen <= 1'b1;
        perf_c2c <= sat_inc(perf_c2c);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected responses, a monitor checks each
// cycle where any dwait/iwait is low.
module tb_mem_arbiter;
  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [1:0]  iREN, iwait, dREN, dWEN, dwait;
  logic [63:0] iaddr, iload, daddr, dstore, dload;
  logic        c2c, dgrant, dbusy, ramREN, ramWEN;
  logic [31:0] ramaddr, ramstore, ramload;
  logic [1:0]  ramstate;
`ifdef ARB_PERF_EN
  logic [63:0] perf_dgrants, perf_igrants, perf_stall;
  logic [31:0] perf_c2c;
`endif

  mem_arbiter #(.CPUS(2), .BLK_WORDS(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait), .c2c(c2c),
    .dgrant(dgrant), .dbusy(dbusy), .ramREN(ramREN), .ramWEN(ramWEN),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
`ifdef ARB_PERF_EN
    , .perf_dgrants(perf_dgrants), .perf_igrants(perf_igrants),
    .perf_c2c(perf_c2c), .perf_stall(perf_stall)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        inst;
    logic        core;
    logic [1:0]  dwait;
    logic [1:0]  iwait;
    logic        dgrant;
    logic        dbusy;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] load;
    logic        chk_store;
    logic        chk_load;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // mode: 0 = read, 1 = write, 2 = read served cache-to-cache
  function automatic exp_t mk_data(input logic core, input int mode, input logic [31:0] addr,
                                   input logic [31:0] load, input logic [31:0] store);
    exp_t e;
    e.inst = 1'b0;  e.core = core;
    e.dwait = core ? 2'b01 : 2'b10;  e.iwait = 2'b11;
    e.dgrant = core;  e.dbusy = 1'b1;
    e.ren = (mode == 0);  e.wen = (mode != 0);
    e.addr = addr;  e.store = store;  e.load = load;
    e.chk_store = (mode != 0);  e.chk_load = (mode == 0);
    return e;
  endfunction

  task automatic serve_block(input logic core, input int mode, input logic [31:0] addr,
                             input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] store);
    for (int w = 0; w < 2; w++) begin
      ramload = (w == 0) ? w0 : w1;
      q.push_back(mk_data(core, mode, addr, ramload, store));
      step();
    end
    if (mode == 1) dWEN[core] = 1'b0;
    else dREN[core] = 1'b0;
  endtask

  task automatic fetch(input logic core, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    ramload = data;
    e.inst = 1'b1;  e.core = core;
    e.dwait = 2'b11;  e.iwait = core ? 2'b01 : 2'b10;
    e.dgrant = 1'b0;  e.dbusy = 1'b0;  e.ren = 1'b1;  e.wen = 1'b0;
    e.addr = addr;  e.store = '0;  e.load = data;
    e.chk_store = 1'b0;  e.chk_load = 1'b1;
    q.push_back(e);
    step();
    iREN[core] = 1'b0;
  endtask

  // Monitor
  initial begin
    exp_t        e;
    logic [31:0] ld;
    logic        ok;
    forever begin
      @(negedge CLK);
      if (nRST && (dwait != 2'b11 || iwait != 2'b11)) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_response: dwait=%b iwait=%b ramaddr=%h, nothing expected",
                   dwait, iwait, ramaddr);
        end else begin
          e  = q.pop_front();
          ld = e.inst ? (e.core ? iload[63:32] : iload[31:0])
                      : (e.core ? dload[63:32] : dload[31:0]);
          ok = (dwait === e.dwait) && (iwait === e.iwait) && (dgrant === e.dgrant) &&
               (dbusy === e.dbusy) && (ramREN === e.ren) && (ramWEN === e.wen) &&
               (ramaddr === e.addr) && (!e.chk_store || ramstore === e.store) &&
               (!e.chk_load || ld === e.load);
          if (!ok) begin
            miscompares++;
            $display("FAIL resp_%0s_core%0d: got dwait=%b iwait=%b grant=%b busy=%b ren=%b wen=%b addr=%h store=%h load=%h; expected dwait=%b iwait=%b grant=%b busy=%b ren=%b wen=%b addr=%h store=%h load=%h",
                     e.inst ? "inst" : "data", e.core, dwait, iwait, dgrant, dbusy, ramREN, ramWEN,
                     ramaddr, ramstore, ld, e.dwait, e.iwait, e.dgrant, e.dbusy, e.ren, e.wen,
                     e.addr, e.store, e.load);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    iREN = '0; iaddr = '0; dREN = '0; dWEN = '0; daddr = '0; dstore = '0;
    c2c = 1'b0; ramload = '0; ramstate = 2'd2;
    repeat (2) step();
    chk("reset_waits", {dwait, iwait}, {2'b11, 2'b11});
    chk("reset_ctrl", {dgrant, dbusy, ramREN, ramWEN}, 4'b0000);
    chk("reset_ramaddr_store", {ramaddr, ramstore}, 64'h0);
    chk("reset_loads", dload | iload, 64'h0);
    nRST = 1'b1;

    // contention from rr=0: core0 then core1
    daddr = {32'h400, 32'h300};
    dREN  = 2'b11;
    step();
    serve_block(1'b0, 0, 32'h300, 32'hA1, 32'hA2, 32'h0);
    step();
    serve_block(1'b1, 0, 32'h400, 32'hB1, 32'hB2, 32'h0);

    // single core0 read block
    daddr[31:0] = 32'h100;
    dREN[0] = 1'b1;
    step();
    serve_block(1'b0, 0, 32'h100, 32'hAA, 32'hBB, 32'h0);
    @(negedge CLK);
    chk("dbusy_after_block", {dbusy, dgrant}, 2'b00);
    step();

    // contention with rr=1: core1 first
    daddr = {32'h440, 32'h340};
    dREN  = 2'b11;
    step();
    serve_block(1'b1, 0, 32'h440, 32'hC1, 32'hC2, 32'h0);
    step();
    serve_block(1'b0, 0, 32'h340, 32'hD1, 32'hD2, 32'h0);

    // core1 read served cache-to-cache: write-back of core0's line
    daddr[63:32] = 32'h200;
    dstore[31:0] = 32'hDEAD;
    c2c = 1'b1;
    dREN[1] = 1'b1;
    step();
    serve_block(1'b1, 2, 32'h200, 32'h0, 32'h0, 32'hDEAD);
    c2c = 1'b0;

    // simultaneous fetch and data request: data first
    iaddr[31:0]  = 32'h500;
    iREN[0]      = 1'b1;
    daddr[63:32] = 32'h600;
    dREN[1]      = 1'b1;
    step();
    serve_block(1'b1, 0, 32'h600, 32'hE1, 32'hE2, 32'h0);
    step();
    fetch(1'b0, 32'h500, 32'h1234);

    // write arriving during a stalled fetch waits for the fetch
    iaddr[31:0] = 32'h700;
    iREN[0]     = 1'b1;
    ramstate    = 2'd1;
    step();
    dWEN[0]      = 1'b1;
    daddr[31:0]  = 32'h800;
    dstore[31:0] = 32'h5555;
    @(negedge CLK);
    chk("inst_stall_busy", {ramREN, ramWEN, iwait, dwait, ramaddr}, {1'b1, 1'b0, 2'b11, 2'b11, 32'h700});
    step();
    ramstate = 2'd3;
    @(negedge CLK);
    chk("inst_stall_error", {ramREN, ramWEN, iwait, dwait}, {1'b1, 1'b0, 2'b11, 2'b11});
    step();
    ramstate = 2'd2;
    fetch(1'b0, 32'h700, 32'h7777);
    step();
    serve_block(1'b0, 1, 32'h800, 32'h0, 32'h0, 32'h5555);

    // reset during word 1, then restart from word 0
    daddr[31:0] = 32'h900;
    dREN[0] = 1'b1;
    step();
    ramload = 32'h11;
    q.push_back(mk_data(1'b0, 0, 32'h900, 32'h11, 32'h0));
    step();
    nRST = 1'b0;
    #1;
    chk("midreset_ctrl", {dbusy, dgrant, ramREN, ramWEN, dwait, iwait}, {4'b0000, 2'b11, 2'b11});
    chk("midreset_bus", {ramaddr, dload[31:0]}, 64'h0);
    @(negedge CLK);
    #1;
    nRST = 1'b1;
    step();
    serve_block(1'b0, 0, 32'h900, 32'h21, 32'h22, 32'h0);
    @(negedge CLK);
    chk("dbusy_after_restart", {dbusy, ramREN}, 2'b00);

    repeat (3) step();
    chk("queue_drained", 64'(q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Dual-core memory arbiter between the two cores' L1 caches (icache + dcache per core) and the single RAM port.
- Sits directly downstream of the coherence controller: it grants one core's data transaction at a time, drives RAM, and consumes the controller's c2c flag to turn snoop-hit reads into memory write-backs.
- Instruction fetches fill idle bus slots.

Parameters:
- CPUS, 2, number of cores; fixed at 2.
- BLK_WORDS, 2, words per cache block; the data grant is held for this many RAM accesses.

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- iREN  in  [CPUS]  instruction read request per core
- iaddr  in  [CPUS]x32  instruction address
- iload  out  [CPUS]x32  instruction data
- iwait  out  [CPUS]  instruction stall; 0 = iload valid this cycle
- dREN  in  [CPUS]  data read request
- dWEN  in  [CPUS]  data write request (write-back)
- daddr  in  [CPUS]x32  data address
- dstore  in  [CPUS]x32  data write value
- dload  out  [CPUS]x32  data read value
- dwait  out  [CPUS]  data stall; 0 = word done this cycle
- c2c  in  1  from coherence control: the current read is served cache-to-cache
- dgrant  out  1  index of the core owning the data bus (valid when dbusy=1)
- dbusy  out  1  a data transaction is in progress
- ramREN  out  1  RAM read
- ramWEN  out  1  RAM write
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR

Behaviour:
- Reset values: all outputs 0 except iwait=dwait='1. FSM=IDLE, rr pointer=0, word counter=0.
- States:
  - IDLE: evaluate requests.
  - DATA: owner latched.
  - INST: one fetch outstanding.
- IDLE arbitration, evaluated every cycle:
  - Any dREN|dWEN → DATA. The owner is the requesting core nearest rr; if both request, the core at rr wins.
  - Otherwise any iREN → INST, same round-robin.
  - Data always beats instruction.
- Entering DATA:
  - dgrant=owner, dbusy=1, counter=0.
  - rr advances to ~owner on exit from DATA.
- DATA, normal read:
  - ramREN=1, ramaddr=daddr[owner].
  - On ramstate==ACCESS: dload[owner]=ramload, dwait[owner]=0, counter+1.
- DATA, write:
  - ramWEN=1, ramstore=dstore[owner], ramaddr=daddr[owner].
  - dwait[owner]=0 on ACCESS.
- DATA, read with c2c=1:
  - No ramREN. Instead ramWEN=1, ramaddr=daddr[owner], ramstore=dstore[~owner] (modified-line write-back).
  - dwait[owner]=0 on ACCESS; dload is driven by coherence control, not this block.
- DATA exit to IDLE:
  - when counter reaches BLK_WORDS, or
  - when the owner deasserts both dREN and dWEN (abandoned).
- The non-owner core's dwait stays 1 for the whole DATA tenure, even while it snoops.
- INST:
  - ramREN=1, ramaddr=iaddr[owner].
  - On ACCESS: iload[owner]=ramload, iwait[owner]=0, return to IDLE next cycle, rr toggles.
  - A data request arriving during INST waits for the fetch to complete (no preemption).
  - If iREN drops before ACCESS, go to IDLE with no response.
- ramstate ERROR: treated as BUSY (stall). ramREN and ramWEN are never both 1.
- Latency: with RAM ACCESS in 1 cycle, a data block finishes 1 cycle after grant + BLK_WORDS cycles.
- Counter is log2(BLK_WORDS)+1 bits and never wraps past BLK_WORDS.
- nRST asserted mid-transaction: immediate return to reset values; no partial RAM strobe after the reset edge.

Optional Feature:
- Macro ARB_PERF_EN.
- Defined: adds outputs
  - perf_dgrants [CPUS]x32: data grants per core.
  - perf_igrants [CPUS]x32: instruction grants per core.
  - perf_c2c 32: DATA tenures with c2c seen.
  - perf_stall [CPUS]x32: cycles with dwait=1 while dREN|dWEN asserted.
  - All counters reset to 0 and saturate at 0xFFFFFFFF.
- Undefined: ports and logic absent; functional behaviour identical.

Test Plan:
- Core0 dREN daddr=0x100, RAM ACCESS each cycle, ramload=0xAA then 0xBB → dload[0]=0xAA then 0xBB, dwait[0] low exactly 2 cycles, dgrant=0, dbusy falls after word 2.
- Both cores dREN the same cycle with rr=0 → core0 served first, core1 dwait=1 throughout, then core1 served; next contention grants core1 first.
- Core1 dREN 0x200 with c2c=1, dstore[0]=0xDEAD → ramWEN=1, ramREN=0, ramaddr=0x200, ramstore=0xDEAD; dwait[1]=0 on ACCESS.
- iREN[0]=1 and dREN[1]=1 simultaneously from IDLE → data first; fetch after the block; iload[0]=ramload when iwait[0]=0.
- dWEN[0] during an in-progress INST fetch → fetch completes first (iwait low 1 cycle), then write with ramWEN=1, ramstore=dstore[0].
- nRST low during DATA word 1 → all outputs at reset values immediately; after release, an identical request restarts at word 0.
